// File: rtl/scorer_pkg.sv
// Shared definitions for the argmax scorer: FSM state encoding, default
// parameter values and the helper that slices one class score out of the
// flattened score bus.
//   latency: n/a (package)
//   backpressure: n/a (package)
package scorer_pkg;

    localparam int DEF_N_CLASSES = 10;
    localparam int DEF_VAL_W     = 16;
    localparam int DEF_CNT_W     = 14;
    localparam int DEF_N_IMAGES  = 10000;

    // Upper bounds of the slicing helper's working vector.
    localparam int SLICE_MAX_CLASSES = 64;
    localparam int SLICE_MAX_W       = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        REPORT   = 2'd2,
        FINISHED = 2'd3
    } scorer_state_e;

    // Returns score i (val_w bits, LSB-aligned) of a zero-extended score bus.
    // Callers truncate the result back to their own score width.
    function automatic logic [SLICE_MAX_W-1:0] score_slice(
        input logic [SLICE_MAX_CLASSES*SLICE_MAX_W-1:0] vec,
        input int                                       val_w,
        input int                                       i
    );
        return vec[i*val_w +: SLICE_MAX_W];
    endfunction

endpackage

// File: rtl/scorer_cmp.sv
// One compare-and-update step of the argmax scan (plus runner-up tracking when
// SCORER_MARGIN_EN is defined).
//   latency: combinational
//   backpressure: none
// Ports: cand/cand_idx = score under test; max_in/idx_in = incumbent;
//        max_out/idx_out = updated incumbent; second_in/second_out = runner-up.
module scorer_cmp
    import scorer_pkg::*;
#(
    parameter int VAL_W = DEF_VAL_W,
    parameter int IDX_W = 4
) (
    input  logic signed [VAL_W-1:0] cand,
    input  logic        [IDX_W-1:0] cand_idx,
    input  logic signed [VAL_W-1:0] max_in,
    input  logic        [IDX_W-1:0] idx_in,
`ifdef SCORER_MARGIN_EN
    input  logic signed [VAL_W-1:0] second_in,
    output logic signed [VAL_W-1:0] second_out,
`endif
    output logic signed [VAL_W-1:0] max_out,
    output logic        [IDX_W-1:0] idx_out
);

    logic wins;

    // Strictly greater: on a tie the earlier (lower-index) incumbent stays.
    assign wins    = cand > max_in;
    assign max_out = wins ? cand : max_in;
    assign idx_out = wins ? cand_idx : idx_in;

`ifdef SCORER_MARGIN_EN
    // A displaced maximum becomes the runner-up; a tie with the maximum lands
    // here too, which is what makes the margin collapse to zero.
    always_comb begin
        second_out = second_in;
        if (wins) begin
            second_out = max_in;
        end else if (cand > second_in) begin
            second_out = cand;
        end
    end
`endif

endmodule

// File: rtl/argmax_scorer.sv
// Argmax classifier scorer: scans one class per cycle, reports the winning
// index, checks it against the label and keeps image/correct totals for a run.
//   latency: accept at edge T -> result_valid during the cycle after edge T+N_CLASSES
//   backpressure: in_ready only in IDLE before the run completes; no output stall
// Ports: clk/rst_b (async active-low), clear (sync restart), in_valid/in_ready +
//        dout/label (input vector), result_valid/inference/correct (strobe),
//        img_cnt/correct_cnt/run_done (run status), margin (SCORER_MARGIN_EN only).
module argmax_scorer
    import scorer_pkg::*;
#(
    parameter  int N_CLASSES = DEF_N_CLASSES,
    parameter  int VAL_W     = DEF_VAL_W,
    parameter  int CNT_W     = DEF_CNT_W,
    parameter  int N_IMAGES  = DEF_N_IMAGES,
    localparam int IDX_W     = $clog2(N_CLASSES)
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_CLASSES*VAL_W-1:0] dout,
    input  logic [IDX_W-1:0]           label,
    output logic                       result_valid,
    output logic [IDX_W-1:0]           inference,
    output logic                       correct,
    output logic [CNT_W-1:0]           img_cnt,
    output logic [CNT_W-1:0]           correct_cnt,
`ifdef SCORER_MARGIN_EN
    output logic [VAL_W:0]             margin,
`endif
    output logic                       run_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
    localparam logic [CNT_W-1:0] IMG_END  = CNT_W'(N_IMAGES);

    scorer_state_e state, state_nxt;

    logic [SLICE_MAX_CLASSES*SLICE_MAX_W-1:0] dout_ext;
    logic signed [VAL_W-1:0] score_in [N_CLASSES];
    logic signed [VAL_W-1:0] score_q  [N_CLASSES];
    logic        [IDX_W-1:0] label_q;
    logic        [IDX_W-1:0] ptr;
    logic signed [VAL_W-1:0] max_q, max_nxt;
    logic        [IDX_W-1:0] idx_q, idx_nxt;
    logic        [CNT_W-1:0] img_cnt_inc;
    logic                    accept;

    always_comb begin
        dout_ext = '0;
        dout_ext[N_CLASSES*VAL_W-1:0] = dout;
    end

    for (genvar g = 0; g < N_CLASSES; g++) begin : g_slice
        assign score_in[g] = VAL_W'(score_slice(dout_ext, VAL_W, g));
    end

    // Gated by rst_b directly so the block advertises nothing while held in reset.
    assign in_ready    = rst_b && (state == IDLE) && !run_done;
    assign accept      = in_valid && in_ready;
    assign img_cnt_inc = img_cnt + CNT_W'(1);

`ifdef SCORER_MARGIN_EN
    logic signed [VAL_W-1:0] second_q, second_nxt;
`endif

    scorer_cmp #(
        .VAL_W (VAL_W),
        .IDX_W (IDX_W)
    ) u_cmp (
        .cand       (score_q[ptr]),
        .cand_idx   (ptr),
        .max_in     (max_q),
        .idx_in     (idx_q),
`ifdef SCORER_MARGIN_EN
        .second_in  (second_q),
        .second_out (second_nxt),
`endif
        .max_out    (max_nxt),
        .idx_out    (idx_nxt)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:     if (accept) state_nxt = SCAN;
                SCAN:     if (ptr == LAST_IDX) state_nxt = REPORT;
                REPORT:   state_nxt = (img_cnt_inc == IMG_END) ? FINISHED : IDLE;
                FINISHED: state_nxt = FINISHED;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < N_CLASSES; i++) score_q[i] <= '0;
            label_q      <= '0;
            ptr          <= '0;
            max_q        <= '0;
            idx_q        <= '0;
            result_valid <= 1'b0;
            inference    <= '0;
            correct      <= 1'b0;
            img_cnt      <= '0;
            correct_cnt  <= '0;
            run_done     <= 1'b0;
`ifdef SCORER_MARGIN_EN
            second_q     <= '0;
            margin       <= '0;
`endif
        end else begin
            result_valid <= 1'b0;
            correct      <= 1'b0;
            if (clear) begin
                img_cnt     <= '0;
                correct_cnt <= '0;
                run_done    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        for (int i = 0; i < N_CLASSES; i++) score_q[i] <= score_in[i];
                        label_q  <= label;
                        max_q    <= score_in[0];
                        idx_q    <= '0;
                        ptr      <= IDX_W'(1);
`ifdef SCORER_MARGIN_EN
                        // Most negative value: any real runner-up replaces it,
                        // and an equal one leaves the same value anyway.
                        second_q <= {1'b1, {(VAL_W-1){1'b0}}};
`endif
                    end
                    SCAN: begin
                        max_q <= max_nxt;
                        idx_q <= idx_nxt;
                        ptr   <= ptr + IDX_W'(1);
`ifdef SCORER_MARGIN_EN
                        second_q <= second_nxt;
`endif
                    end
                    REPORT: begin
                        result_valid <= 1'b1;
                        inference    <= idx_q;
                        correct      <= (idx_q == label_q);
                        img_cnt      <= img_cnt_inc;
                        if (idx_q == label_q) correct_cnt <= correct_cnt + CNT_W'(1);
                        if (img_cnt_inc == IMG_END) run_done <= 1'b1;
`ifdef SCORER_MARGIN_EN
                        margin <= {max_q[VAL_W-1], max_q} - {second_q[VAL_W-1], second_q};
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/argmax_scorer.md
ARGMAX_SCORER -- requirements
Module: argmax_scorer

Interface
REQ-001 Parameter N_CLASSES, default 10, number of class scores per image (2..64).
REQ-002 Parameter VAL_W, default 16, width of each signed class score.
REQ-003 Parameter CNT_W, default 14, width of image and correct counters.
REQ-004 Parameter N_IMAGES, default 10000, image count that ends a run (1..2^CNT_W-1).
REQ-005 Localparam IDX_W = $clog2(N_CLASSES), the width of the class index.
REQ-006 Port clk  in  1  single clock; all logic is rising-edge.
REQ-007 Port rst_b  in  1  reset, asynchronous, active-low.
REQ-008 Port clear  in  1  synchronous run restart.
REQ-009 Port in_valid  in  1  score vector and label present.
REQ-010 Port in_ready  out  1  block accepts a vector.
REQ-011 Port dout  in  N_CLASSES*VAL_W  signed scores; class i is at bits [VAL_W*(i+1)-1 : VAL_W*i].
REQ-012 Port label  in  IDX_W  expected class.
REQ-013 Port result_valid  out  1  one-cycle result strobe.
REQ-014 Port inference  out  IDX_W  winning class index.
REQ-015 Port correct  out  1  inference equals label; valid only with result_valid.
REQ-016 Port img_cnt / correct_cnt  out  CNT_W each  running totals.
REQ-017 Port run_done  out  1  sticky flag, set once img_cnt reaches N_IMAGES.

Function
REQ-018 FSM states: IDLE, SCAN, REPORT, FINISHED.
REQ-019 in_ready=1 only in IDLE with run_done=0.
REQ-020 Accept on an edge where in_valid && in_ready: capture dout and label, set max=score[0], idx=0, ptr=1, go to SCAN.
REQ-021 SCAN: one class per cycle; if signed score[ptr] > max then max=score[ptr], idx=ptr; after ptr=N_CLASSES-1 go to REPORT.
REQ-022 Comparison is strictly signed greater-than, so ties resolve to the lowest index.
REQ-023 Latency: if acceptance is at edge T, result_valid is high for exactly the cycle following edge T+N_CLASSES.
REQ-024 REPORT: drive inference=idx and correct=(idx==label) in the same cycle as result_valid, and increment img_cnt and, when correct, correct_cnt by one at the same edge.
REQ-025 After REPORT: go to FINISHED and set run_done if the new img_cnt==N_IMAGES; otherwise go to IDLE.
REQ-026 FINISHED holds in_ready=0 and the counters frozen until clear.
REQ-027 clear has priority over everything: at the next edge go to IDLE, zero both counters, run_done and result_valid, and discard any scan in flight.
REQ-028 inference keeps its last value between strobes; correct is 0 outside result_valid.
REQ-029 Input dout and label may change after acceptance without affecting the result.
REQ-030 Counters never wrap: N_IMAGES bounds img_cnt, and correct_cnt <= img_cnt.

Reset
REQ-031 rst_b low asynchronously forces IDLE; in_ready=0 while rst_b is low and 1 from the first cycle after release; all other outputs 0.
REQ-032 Reset asserted mid-scan aborts the scan with no strobe and no count change.

Configuration
REQ-033 With SCORER_MARGIN_EN defined, the block adds an output port margin (VAL_W+1 bits, unsigned) equal to the winning score minus the second-highest score.
REQ-034 The margin is valid with result_valid and is 0 when the top two scores are equal.
REQ-035 Without SCORER_MARGIN_EN, the margin port and the second-max tracking logic are absent; all other behaviour is identical.

Structure
REQ-036 Shared package scorer_pkg holds the state enum, the default parameter constants and a function that slices score i out of dout.
REQ-037 The compare-and-update step is one sub-module, scorer_cmp: combinational, signed, tie-keeps-incumbent, plus the optional second-max update.

Verification
REQ-038 N_CLASSES=10, scores {0,5,-3,9,2,9,1,0,0,-8}, label=3 -> result_valid at edge T+10, inference=3, correct=1, img_cnt=1, correct_cnt=1.
REQ-039 All scores -100 except score[7]=-1, label=2 -> inference=7, correct=0, img_cnt increments, correct_cnt unchanged.
REQ-040 N_IMAGES=3, three back-to-back vectors -> run_done=1 after the third strobe; a fourth in_valid is not accepted; clear -> in_ready=1 and counters 0.
REQ-041 rst_b pulsed low at scan cycle 4 -> no result_valid, counters 0, in_ready=1 from the first cycle after release.
REQ-042 clear and result_valid in the same cycle -> counters 0 at the next edge, state IDLE.
REQ-043 SCORER_MARGIN_EN, scores max 0x7FFF and second 0x8000 -> margin=0xFFFF (17 bits); with equal top scores -> margin=0.
